// File: rtl/spi_tx_if.sv
// Load-side bus of spi_tx_engine: parallel word, per-frame config, status and SPI pins.
// SPI_TX_READBACK_EN adds miso/rx_data and the SHIFT_COUNT parameter that sizes rx_data.
interface spi_tx_if #(
`ifdef SPI_TX_READBACK_EN
  parameter int SHIFT_COUNT = 24,
`endif
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 16,
  parameter int NUM_CS     = 1
);
  localparam int CS_WIDTH = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  // ld/ready: a load is taken on the rising clk edge where ld and ready are both 1;
  // ld while ready=0 is dropped, and ready never depends on ld in the same cycle.
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ld;
  logic [CS_WIDTH-1:0]   cs_sel;
  logic [DIV_WIDTH-1:0]  clk_div;
  logic                  cpol;
  logic                  cpha;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  sclk;
  logic                  mosi;
  logic [NUM_CS-1:0]     cs_n;
`ifdef SPI_TX_READBACK_EN
  logic                   miso;
  logic [SHIFT_COUNT-1:0] rx_data;

  modport master (output data_in, ld, cs_sel, clk_div, cpol, cpha, miso,
                  input  ready, busy, done, sclk, mosi, cs_n, rx_data);
  modport slave  (input  data_in, ld, cs_sel, clk_div, cpol, cpha, miso,
                  output ready, busy, done, sclk, mosi, cs_n, rx_data);
`else
  modport master (output data_in, ld, cs_sel, clk_div, cpol, cpha,
                  input  ready, busy, done, sclk, mosi, cs_n);
  modport slave  (input  data_in, ld, cs_sel, clk_div, cpol, cpha,
                  output ready, busy, done, sclk, mosi, cs_n);
`endif
endinterface

// File: rtl/spi_tx_engine.sv
// SPI master transmit engine: MSB-first frame of SHIFT_COUNT bits, runtime divider/mode/chip select.
// Optional SPI_TX_READBACK_EN samples miso into rx_data on the sampling sclk edges.
module spi_tx_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_COUNT = 24,
  parameter int DIV_WIDTH   = 16,
  parameter int NUM_CS      = 1
) (
  input  logic       clk,
  input  logic       rst,
  spi_tx_if.slave    bus,
  output logic [2:0] fsm_state
);
  localparam int CS_WIDTH  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int BIT_WIDTH = $clog2(SHIFT_COUNT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SHIFT_COUNT-1:0] sh_q;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic [BIT_WIDTH-1:0]   bit_cnt;
  logic [CS_WIDTH-1:0]    cs_q;
  logic                   cpol_q;
  logic                   cpha_q;
  logic                   sclk_q;
  logic                   mosi_q;
  logic                   ready;
  logic                   done;
  logic [NUM_CS-1:0]      cs_n;
  logic                   accept;
  logic                   tick;
  logic                   lead_edge;
  logic                   trail_edge;
  logic                   last_trail;
  logic                   launch;

  assign accept     = bus.ld && (state == S_IDLE);
  assign tick       = (div_cnt == div_q);
  // sclk still at cpol means the next toggle is a leading edge
  assign lead_edge  = (state == S_SHIFT) && tick && (sclk_q == cpol_q);
  assign trail_edge = (state == S_SHIFT) && tick && (sclk_q != cpol_q);
  assign last_trail = trail_edge && (bit_cnt == BIT_WIDTH'(SHIFT_COUNT - 1));
  assign launch     = cpha_q ? lead_edge : (trail_edge && !last_trail);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SETUP;
      S_SETUP: if (tick) state_nxt = S_SHIFT;
      S_SHIFT: if (last_trail) state_nxt = S_HOLD;
      S_HOLD:  if (tick) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    cs_n  = '1;
    case (state)
      S_IDLE: ready = 1'b1;
      S_SETUP, S_SHIFT, S_HOLD: begin
        for (int i = 0; i < NUM_CS; i++) begin
          if (int'(cs_q) == i) cs_n[i] = 1'b0;
        end
      end
      S_DONE: done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // With cpha=0 the MSB is already on mosi during SETUP, so the shifter is preloaded one bit ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q    <= '0;
      div_q   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      cs_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else if (accept) begin
      sh_q    <= bus.cpha ? bus.data_in[SHIFT_COUNT-1:0] : (bus.data_in[SHIFT_COUNT-1:0] << 1);
      mosi_q  <= bus.cpha ? 1'b0 : bus.data_in[SHIFT_COUNT-1];
      div_q   <= bus.clk_div;
      cs_q    <= bus.cs_sel;
      cpol_q  <= bus.cpol;
      cpha_q  <= bus.cpha;
      sclk_q  <= bus.cpol;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (state == S_DONE) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (state != S_IDLE) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if ((state == S_SHIFT) && tick) sclk_q <= ~sclk_q;
      if (trail_edge) bit_cnt <= bit_cnt + 1'b1;
      if (launch) begin
        mosi_q <= sh_q[SHIFT_COUNT-1];
        sh_q   <= sh_q << 1;
      end
      if ((state == S_HOLD) && tick) mosi_q <= 1'b0;
    end
  end

`ifdef SPI_TX_READBACK_EN
  logic [SHIFT_COUNT-1:0] rx_q;
  logic                   sample;

  assign sample = cpha_q ? trail_edge : lead_edge;

  always_ff @(posedge clk) begin
    if (rst)         rx_q <= '0;
    else if (accept) rx_q <= '0;
    else if (sample) rx_q <= (rx_q << 1) | SHIFT_COUNT'(bus.miso);
  end

  assign bus.rx_data = rx_q;
`endif

  generate
    if (SHIFT_COUNT < DATA_WIDTH) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^bus.data_in[DATA_WIDTH-1:SHIFT_COUNT];
    end
  endgenerate

  assign bus.ready = ready;
  assign bus.busy  = ~ready;
  assign bus.done  = done;
  assign bus.sclk  = sclk_q;
  assign bus.mosi  = mosi_q;
  assign bus.cs_n  = cs_n;
  assign fsm_state = state;
endmodule

// File: tb/tb_spi_tx_engine.sv
// Bench for spi_tx_engine: directed and random frames checked against a pin-level SPI slave model.
`timescale 1ns/1ps
module tb_spi_tx_engine;
  localparam int DW   = 32;
  localparam int SC   = 24;
  localparam int DIVW = 16;
  localparam int NCS  = 5;
  localparam int CSW  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] fsm_state;
  int         tests = 0;
  int         fails = 0;

  spi_tx_if #(
`ifdef SPI_TX_READBACK_EN
    .SHIFT_COUNT(SC),
`endif
    .DATA_WIDTH(DW), .DIV_WIDTH(DIVW), .NUM_CS(NCS)
  ) bus ();

  spi_tx_engine #(
    .DATA_WIDTH(DW), .SHIFT_COUNT(SC), .DIV_WIDTH(DIVW), .NUM_CS(NCS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame from a negedge and watches the pins like an SPI slave would.
  // Returns at the negedge of the cycle after done.
  task automatic run_frame(input logic [DW-1:0] data, input int div, input bit pol, input bit pha,
                           input int cs, input logic [SC-1:0] slave, input bit ld_busy,
                           input bit ld_done);
    int h, exp_len, done_cyc, edges, rises, run, cs_err, run_err, stab_err, chg_err, nsamp;
    logic [NCS-1:0] exp_cs;
    logic [SC-1:0]  cap, exp_word;
    logic           ps, pm, s, m, samp, launch_e;
    h = div + 1;
    exp_len = 1 + h * (2 * SC + 2);
    exp_word = data[SC-1:0];
    for (int i = 0; i < NCS; i++) exp_cs[i] = (i != cs);
    done_cyc = 0; edges = 0; rises = 0; run = 0; cs_err = 0; run_err = 0;
    stab_err = 0; chg_err = 0; nsamp = 0; cap = '0; ps = pol; pm = 1'b0;
    bus.data_in = data;
    bus.clk_div = DIVW'(div);
    bus.cpol    = pol;
    bus.cpha    = pha;
    bus.cs_sel  = CSW'(cs);
    bus.ld      = 1'b1;
`ifdef SPI_TX_READBACK_EN
    bus.miso    = slave[SC-1];
`endif
    @(posedge clk);
    for (int cyc = 1; cyc <= exp_len + 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.ld = 1'b0;
        check("busy_after_ld", {bus.ready, bus.busy}, 2'b01);
      end
      if (ld_busy && cyc == 7) begin
        bus.ld = 1'b1; bus.data_in = ~data; bus.clk_div = DIVW'(div + 5);
        bus.cpol = ~pol; bus.cpha = ~pha; bus.cs_sel = '0;
      end
      if (ld_busy && cyc == 8) bus.ld = 1'b0;
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      s = bus.sclk;
      m = bus.mosi;
      if (bus.cs_n !== exp_cs) cs_err++;
      samp = 1'b0;
      launch_e = 1'b0;
      if (s != ps) begin
        edges++;
        if (s) rises++;
        if (edges >= 2 && run != h) run_err++;
        run = 0;
        samp = pha ? (s == pol) : (s != pol);
        launch_e = !samp;
      end
      run++;
      if (m != pm && cyc != 1 && !launch_e) chg_err++;
      if (samp) begin
        if (m != pm) stab_err++;
        cap = {cap[SC-2:0], pm};
        nsamp++;
`ifdef SPI_TX_READBACK_EN
        bus.miso = (nsamp < SC) ? slave[SC-1-nsamp] : 1'b0;
`endif
      end
      ps = s;
      pm = m;
    end
    check("done_cycle", done_cyc, exp_len);
    check("mosi_word", cap, exp_word);
    check("sclk_rises", rises, SC);
    check("sclk_edges", edges, 2 * SC);
    check("cs_n_active", cs_err, 0);
    check("sclk_level_len", run_err, 0);
    check("mosi_stable_at_sample", stab_err, 0);
    check("mosi_change_edge", chg_err, 0);
    check("done_sclk_idle", bus.sclk, pol);
    check("done_mosi", bus.mosi, 1'b0);
    check("done_cs_n", bus.cs_n, {NCS{1'b1}});
`ifdef SPI_TX_READBACK_EN
    check("rx_data", bus.rx_data, slave);
`endif
    if (ld_done) begin
      bus.ld = 1'b1;
      bus.data_in = $urandom;
    end
    @(negedge clk);
    check("done_pulse_width", bus.done, 1'b0);
    check("ready_after_done", {bus.ready, bus.busy}, 2'b10);
  endtask

  initial begin
    int dn;
    bus.ld = 1'b0; bus.data_in = '0; bus.cs_sel = '0; bus.clk_div = '0;
    bus.cpol = 1'b0; bus.cpha = 1'b0;
`ifdef SPI_TX_READBACK_EN
    bus.miso = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready_busy", {bus.ready, bus.busy}, 2'b10);
    check("rst_done", bus.done, 1'b0);
    check("rst_sclk", bus.sclk, 1'b0);
    check("rst_mosi", bus.mosi, 1'b0);
    check("rst_cs_n", bus.cs_n, {NCS{1'b1}});

    // Abort a cpol=1 frame with reset: everything returns to reset values, no done.
    bus.data_in = 32'h00A5A5A5; bus.clk_div = 16'd1; bus.cpol = 1'b1; bus.cpha = 1'b0;
    bus.cs_sel = 3'd0; bus.ld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ld = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cs_n", bus.cs_n, {NCS{1'b1}});
    check("abort_sclk", bus.sclk, 1'b0);
    check("abort_mosi", bus.mosi, 1'b0);
    check("abort_ready", {bus.ready, bus.busy}, 2'b10);
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    check("abort_no_done", dn, 0);

    run_frame(32'hFFC35A3C, 0, 1'b0, 1'b0, 2, 24'h0, 1'b0, 1'b0);
    run_frame(32'h00000001, 3, 1'b1, 1'b1, 0, 24'h0, 1'b0, 1'b0);
    run_frame(32'h12345678, 0, 1'b0, 1'b0, 5, 24'h0, 1'b0, 1'b0);
    run_frame(32'hDEADBEEF, 2, 1'b0, 1'b1, 1, 24'h0, 1'b1, 1'b1);
    run_frame(32'h0055AA33, 1, 1'b1, 1'b0, 4, 24'h0, 1'b0, 1'b0);
    run_frame(32'h00C0FFEE, 1, 1'b0, 1'b1, 3, 24'h9A0F17, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run_frame($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 6),
                24'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
